// File: rtl/dac_channel_scheduler_if.sv
// ---------------------------------------------------------------------------
// dac_channel_scheduler_if
// Stream link between the channel scheduler and the AD5318 SPI driver.
//   tdata  [15:0] : stream word (control word or zero-extended channel data)
//   tuser  [2:0]  : channel index, 0 for the control word
//   tvalid        : word valid, held until accepted
//   tready        : downstream ready
// master modport : the scheduler (drives tdata/tuser/tvalid)
// slave modport  : the DAC driver (drives tready)
// ---------------------------------------------------------------------------
interface dac_channel_scheduler_if;
  logic [15:0] tdata;
  logic [2:0]  tuser;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata,
    output tuser,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/dac_channel_scheduler.sv
// ---------------------------------------------------------------------------
// dac_channel_scheduler
// Keeps a shadow value per DAC channel, tracks which channels changed and
// forwards one stream beat per changed channel with round-robin fairness.
// After reset an optional control word is sent ahead of any data.
//
// Ports:
//   clkin      : system clock, all logic on posedge
//   rstn       : asynchronous active-low reset
//   wr_en      : write strobe, always accepted
//   wr_ch      : channel index of the write
//   wr_data    : new channel value
//   force_all  : single-cycle pulse, marks every channel dirty
//   stream     : tdata/tuser/tvalid/tready link to the DAC driver (master)
//   pending    : per-channel dirty flags
//   busy       : high while in INIT or SEND
// ---------------------------------------------------------------------------
module dac_channel_scheduler #(
  parameter int          NUM_CH    = 8,
  parameter int          DATA_W    = 10,
  parameter logic        SEND_INIT = 1'b1,
  parameter logic [15:0] INIT_WORD = 16'h8000
) (
  input  logic                      clkin,
  input  logic                      rstn,
  input  logic                      wr_en,
  input  logic [2:0]                wr_ch,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      force_all,
  dac_channel_scheduler_if.master   stream,
  output logic [NUM_CH-1:0]         pending,
  output logic                      busy
);

  localparam int CH_W  = 3;
  localparam int PAD_W = 16 - DATA_W;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND
  } state_t;

  localparam state_t RESET_STATE = SEND_INIT ? ST_INIT : ST_IDLE;

  state_t              state_reg, state_next;
  logic                tvalid_reg, tvalid_next;
  logic [15:0]         tdata_reg, tdata_next;
  logic [CH_W-1:0]     tuser_reg, tuser_next;
  logic [CH_W-1:0]     rr_reg, rr_next;
  logic [NUM_CH-1:0]   pending_reg, pending_next;
  logic                busy_reg;
  logic [DATA_W-1:0]   shadow_reg [NUM_CH];

  logic [NUM_CH-1:0]   pend_rot;
  logic [NUM_CH-1:0]   pend_clr;
  logic [NUM_CH-1:0]   wr_mask;
  logic [CH_W-1:0]     sel_offs;
  logic [CH_W-1:0]     sel;
  logic                any_pending;

  // Pending vector rotated so that bit 0 is the channel at the round-robin
  // pointer; the lowest set bit of the rotated vector is the next winner.
  // The 3-bit index addition wraps modulo 8 by itself.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
      logic [CH_W-1:0] src_idx;
      assign src_idx      = CH_W'(gi) + rr_reg;
      assign pend_rot[gi] = pending_reg[src_idx];
      assign wr_mask[gi]  = wr_en && (wr_ch == CH_W'(gi));
    end
  endgenerate

  always_comb begin
    sel_offs = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_rot[i]) begin
        sel_offs = CH_W'(i);
      end
    end
  end

  assign sel         = rr_reg + sel_offs;
  assign any_pending = |pending_reg;

  // Next-state and output logic
  always_comb begin
    state_next  = state_reg;
    tvalid_next = tvalid_reg;
    tdata_next  = tdata_reg;
    tuser_next  = tuser_reg;
    rr_next     = rr_reg;
    pend_clr    = '0;

    case (state_reg)
      ST_INIT: begin
        if (tvalid_reg && stream.tready) begin
          tvalid_next = 1'b0;
          state_next  = ST_IDLE;
        end else begin
          tvalid_next = 1'b1;
          tdata_next  = INIT_WORD;
          tuser_next  = '0;
        end
      end

      ST_IDLE: begin
        if (any_pending) begin
          tvalid_next    = 1'b1;
          tdata_next     = {{PAD_W{1'b0}}, shadow_reg[sel]};
          tuser_next     = sel;
          pend_clr[sel]  = 1'b1;
          rr_next        = sel + CH_W'(1);
          state_next     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (stream.tready) begin
          tvalid_next = 1'b0;
          state_next  = ST_IDLE;
        end
      end

      default: begin
        tvalid_next = 1'b0;
        state_next  = ST_IDLE;
      end
    endcase

    // A write or force_all on the load edge wins over the clear, so the
    // freshly written value is sent again later.
    pending_next = (pending_reg & ~pend_clr) | wr_mask | {NUM_CH{force_all}};
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= RESET_STATE;
      tvalid_reg  <= 1'b0;
      tdata_reg   <= '0;
      tuser_reg   <= '0;
      rr_reg      <= '0;
      pending_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tvalid_reg  <= tvalid_next;
      tdata_reg   <= tdata_next;
      tuser_reg   <= tuser_next;
      rr_reg      <= rr_next;
      pending_reg <= pending_next;
      busy_reg    <= (state_next != ST_IDLE);
    end
  end

  // Shadow values; the IDLE load reads the value held before this edge,
  // so a write on the load edge does not affect the beat in flight.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_shadow
      always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
          shadow_reg[gi] <= '0;
        end else if (wr_mask[gi]) begin
          shadow_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign stream.tvalid = tvalid_reg;
  assign stream.tdata  = tdata_reg;
  assign stream.tuser  = tuser_reg;
  assign pending       = pending_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dac_channel_scheduler
// Directed scenarios plus randomized traffic for dac_channel_scheduler,
// checked every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_dac_channel_scheduler;
  localparam logic [15:0] INIT_WORD = 16'h8000;

  logic       clkin = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_ch = '0;
  logic [9:0] wr_data = '0;
  logic       force_all = 1'b0;
  logic [7:0] pending;
  logic       busy;

  dac_channel_scheduler_if stream ();

  dac_channel_scheduler dut (
    .clkin     (clkin),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .force_all (force_all),
    .stream    (stream),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: the link either carries a word or is empty; an empty
  // link picks the init word first, then the next dirty channel from rr.
  bit          m_valid;
  bit          m_init;
  logic [15:0] m_data;
  int          m_user;
  logic [9:0]  m_shadow [8];
  bit   [7:0]  m_pend;
  int          m_rr;

  // DUT beats observed at the accepting edge
  int          obs_user [$];
  logic [15:0] obs_data [$];
  int          obs_cyc  [$];
  bit          s_valid = 0;
  logic [15:0] s_data;
  int          s_user;

  task automatic model_reset();
    m_valid = 0;
    m_init  = 1;
    m_data  = '0;
    m_user  = 0;
    m_pend  = '0;
    m_rr    = 0;
    for (int i = 0; i < 8; i++) m_shadow[i] = '0;
  endtask

  task automatic model_edge();
    if (m_valid) begin
      if (stream.tready) begin
        m_valid = 0;
        m_init  = 0;
      end
    end else if (m_init) begin
      m_valid = 1;
      m_data  = INIT_WORD;
      m_user  = 0;
    end else if (m_pend != 0) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_rr + k) % 8;
        if (m_pend[c] && !m_valid) begin
          m_valid   = 1;
          m_data    = 16'(m_shadow[c]);
          m_user    = c;
          m_pend[c] = 0;
          m_rr      = (c + 1) % 8;
        end
      end
    end
    if (wr_en) begin
      m_shadow[wr_ch] = wr_data;
      m_pend[wr_ch]   = 1;
    end
    if (force_all) m_pend = 8'hFF;
  endtask

  task automatic step();
    @(posedge clkin);
    if (rstn) begin
      if (s_valid && stream.tready) begin
        obs_user.push_back(s_user);
        obs_data.push_back(s_data);
        obs_cyc.push_back(cyc);
      end
      model_edge();
    end
    cyc++;
    @(negedge clkin);
    check_eq("tvalid", 32'(stream.tvalid), 32'(m_valid));
    check_eq("pending", 32'(pending), 32'(m_pend));
    check_eq("busy", 32'(busy), 32'(m_valid || m_init));
    if (m_valid) begin
      check_eq("tdata", 32'(stream.tdata), 32'(m_data));
      check_eq("tuser", 32'(stream.tuser), 32'(m_user));
    end
    s_valid = stream.tvalid;
    s_data  = stream.tdata;
    s_user  = 32'(stream.tuser);
  endtask

  task automatic do_write(input int ch, input logic [9:0] val);
    wr_en   = 1'b1;
    wr_ch   = 3'(ch);
    wr_data = val;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic clear_obs();
    obs_user.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  initial begin
    bit [7:0] seen;
    stream.tready = 1'b0;
    model_reset();

    // Reset state
    #1;
    check_eq("rst_tvalid", 32'(stream.tvalid), 0);
    check_eq("rst_tdata", 32'(stream.tdata), 0);
    check_eq("rst_tuser", 32'(stream.tuser), 0);
    check_eq("rst_pending", 32'(pending), 0);
    check_eq("rst_busy", 32'(busy), 0);
    @(negedge clkin);
    @(negedge clkin);
    rstn = 1'b1;
    stream.tready = 1'b1;

    // Init word after reset
    repeat (4) step();
    check_eq("init_count", obs_user.size(), 1);
    if (obs_user.size() == 1) begin
      check_eq("init_data", 32'(obs_data[0]), 32'h8000);
      check_eq("init_user", obs_user[0], 0);
    end
    clear_obs();

    // Single write
    do_write(5, 10'h3FF);
    repeat (4) step();
    check_eq("single_count", obs_user.size(), 1);
    if (obs_user.size() == 1) begin
      check_eq("single_data", 32'(obs_data[0]), 32'h03FF);
      check_eq("single_user", obs_user[0], 5);
    end
    check_eq("single_pend", 32'(pending), 0);
    clear_obs();

    // Burst with stalled link, round-robin order 1,2,6
    stream.tready = 1'b0;
    do_write(1, 10'h001);
    do_write(6, 10'h002);
    do_write(2, 10'h003);
    step();
    stream.tready = 1'b1;
    repeat (8) step();
    check_eq("rr_count", obs_user.size(), 3);
    if (obs_user.size() == 3) begin
      check_eq("rr_u0", obs_user[0], 1);
      check_eq("rr_u1", obs_user[1], 2);
      check_eq("rr_u2", obs_user[2], 6);
      check_eq("rr_d1", 32'(obs_data[1]), 32'h0003);
    end
    clear_obs();

    // Wrap: rr=7, ch5 goes first, then 0 and 3 pend together -> 5,0,3
    stream.tready = 1'b0;
    do_write(5, 10'h055);
    step();
    do_write(3, 10'h033);
    do_write(0, 10'h044);
    stream.tready = 1'b1;
    repeat (8) step();
    check_eq("wrap_count", obs_user.size(), 3);
    if (obs_user.size() == 3) begin
      check_eq("wrap_u0", obs_user[0], 5);
      check_eq("wrap_u1", obs_user[1], 0);
      check_eq("wrap_u2", obs_user[2], 3);
    end
    clear_obs();

    // Write to the channel currently in SEND
    stream.tready = 1'b0;
    do_write(4, 10'h020);
    step();
    do_write(4, 10'h010);
    step();
    check_eq("hold_tdata", 32'(stream.tdata), 32'h0020);
    check_eq("hold_repend", 32'(pending[4]), 1);
    stream.tready = 1'b1;
    repeat (6) step();
    check_eq("hold_count", obs_user.size(), 2);
    if (obs_user.size() == 2) begin
      check_eq("hold_d0", 32'(obs_data[0]), 32'h0020);
      check_eq("hold_d1", 32'(obs_data[1]), 32'h0010);
    end
    clear_obs();

    // force_all: every channel once, beats at least 2 cycles apart
    force_all = 1'b1;
    step();
    force_all = 1'b0;
    repeat (24) step();
    check_eq("force_count", obs_user.size(), 8);
    seen = '0;
    foreach (obs_user[i]) seen[obs_user[i]] = 1'b1;
    check_eq("force_cover", 32'(seen), 32'hFF);
    for (int i = 1; i < obs_cyc.size(); i++)
      check_eq("force_gap", 32'(obs_cyc[i] - obs_cyc[i-1] >= 2), 1);
    clear_obs();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      wr_en         = ($urandom_range(0, 99) < 30);
      wr_ch         = 3'($urandom_range(0, 7));
      wr_data       = 10'($urandom);
      force_all     = ($urandom_range(0, 99) < 2);
      stream.tready = ($urandom_range(0, 99) < 60);
      step();
    end
    wr_en = 1'b0;
    force_all = 1'b0;
    stream.tready = 1'b1;
    repeat (30) step();
    check_eq("drain_pend", 32'(pending), 0);
    check_eq("drain_tvalid", 32'(stream.tvalid), 0);
    clear_obs();

    // Reset in the middle of a stalled beat
    stream.tready = 1'b0;
    do_write(2, 10'h2AA);
    step();
    check_eq("mid_tvalid", 32'(stream.tvalid), 1);
    #2 rstn = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", 32'(stream.tvalid), 0);
    check_eq("mid_rst_pend", 32'(pending), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    model_reset();
    s_valid = 0;
    @(negedge clkin);
    rstn = 1'b1;
    stream.tready = 1'b1;
    repeat (6) step();
    check_eq("reinit_count", obs_user.size(), 1);
    if (obs_user.size() == 1) begin
      check_eq("reinit_data", 32'(obs_data[0]), 32'h8000);
      check_eq("reinit_user", obs_user[0], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
